multichannel_history_ram: RTL and testbench
===========================================

// Module: multichannel_history_ram
// PURPOSE
//  Per-channel circular sample-history buffer on a single clock, for the SRC polyphase filter datapath.
//  Sits between the input sample stream and the FIR MAC engine.
//  Writes push the newest sample of a channel. Reads fetch "sample d steps back" by delay index.
//  Fixed 2-cycle read latency. Storage is one block RAM of 2**(CH_WIDTH+ADDR_WIDTH) words, addressed {ch, ptr}.
// PARAMETERS
//  DATA_WIDTH  32  sample word width
//  ADDR_WIDTH  8   log2 of per-channel depth; DEPTH = 2**ADDR_WIDTH
//  CH_WIDTH    2   log2 of channel count; NCH = 2**CH_WIDTH
// PORTS
//  clk       in   1           single clock; all logic on posedge
//  rst       in   1           synchronous, active-high reset
//  wr_en     in   1           push wr_data into channel wr_ch
//  wr_ch     in   CH_WIDTH    write channel
//  wr_data   in   DATA_WIDTH  sample to push
//  clr_en    in   1           clear history of channel clr_ch
//  clr_ch    in   CH_WIDTH    channel to clear
//  rd_en     in   1           read request
//  rd_ch     in   CH_WIDTH    read channel
//  rd_delay  in   ADDR_WIDTH  0 = newest sample, DEPTH-1 = oldest
//  rd_valid  out  1           rd_data/rd_oor valid; asserted 2 cycles after rd_en
//  rd_data   out  DATA_WIDTH  read sample
//  rd_oor    out  1           requested delay >= samples held (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: wptr[all]=0, fill[all]=0, rd_valid=0, rd_data=0, rd_oor=0. Memory contents not reset.
//    In-flight reads are discarded: rd_valid=0 on the cycle after rst.
//  - Write at cycle T: mem[{wr_ch,wptr[wr_ch]}] <= wr_data; wptr[wr_ch] <= wptr+1 (mod DEPTH, wraps silently).
//    With fill tracking, fill[wr_ch] <= min(fill+1, DEPTH); fill is ADDR_WIDTH+1 bits wide.
//  - Read accepted at T: addr = {rd_ch, wptr[rd_ch] - 1 - rd_delay} mod DEPTH, computed from pre-write state at T.
//    RAM read is registered at edge T (read-first). Output register updates at edge T+1.
//    rd_valid pulses for one cycle per request. Back-to-back requests give one result per cycle.
//  - Same-cycle write + read, same channel: the read sees pre-write state.
//    delay 0 returns the previously written sample, not wr_data.
//    delay DEPTH-1 addresses the slot being overwritten and must return the old (evicted) word.
//  - Clear at T: wptr[clr_ch] <= 0, fill[clr_ch] <= 0; RAM untouched.
//    Clear beats a write to the same channel in the same cycle; that write is dropped entirely.
//    A read in the same cycle uses pre-clear state. Other channels are unaffected.
//  - rd_valid=0 cycles: rd_data/rd_oor hold their last value.
//  - No backpressure; every request completes. Channels are fully independent.
// CONFIGURATION
//  Macro: HISTORY_FILL_TRACK_EN
//  Defined:
//    - per-channel fill counters are built.
//    - rd_oor=1 when rd_delay >= fill[rd_ch] at T.
//    - an oor read returns rd_data = 0, not memory contents.
//  Undefined:
//    - no fill counters; rd_oor tied to 0.
//    - rd_data is always raw memory contents, possibly stale.
//    - clear resets wptr only.
// TESTING
//  1. rst; push 1,2,3 to ch0; read ch0 delay 0,1,2 back-to-back -> rd_data 3,2,1 on 3 consecutive cycles, first 2 cycles after rd_en.
//  2. ADDR_WIDTH=3: push 0..9 to ch1; read delay 0 and delay 7 -> 9 and 2 (wrap-around).
//  3. Full ch2 (DEPTH samples); same cycle write 0xAA and read delay DEPTH-1 -> returns oldest sample, not 0xAA; then delay 0 -> 0xAA.
//  4. Interleave ch0 = 0x10+n and ch3 = 0x30+n, 5 each; read ch3 delay 4 -> 0x30; ch0 delay 0 -> 0x14; then clr ch0 and read delay 0 ->
//     FILL_TRACK_EN: rd_oor=1, data 0; else rd_oor=0.
//  5. FILL_TRACK_EN: push 2 samples; read delay 2 -> rd_oor=1, rd_data=0; delay 1 -> rd_oor=0.
//  6. Issue read, assert rst the next cycle -> no rd_valid pulse; outputs 0; subsequent push/read works from empty state.

Source files
------------

// File: rtl/multichannel_history_ram_if.sv
// Request/response bundle for multichannel_history_ram: push, clear and delayed-read ports.
// The master side issues requests; the slave side (the RAM) returns read results.
interface multichannel_history_ram_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CH_WIDTH   = 2
);
  logic                  wr_en;
  logic [CH_WIDTH-1:0]   wr_ch;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  clr_en;
  logic [CH_WIDTH-1:0]   clr_ch;
  logic                  rd_en;
  logic [CH_WIDTH-1:0]   rd_ch;
  logic [ADDR_WIDTH-1:0] rd_delay;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_oor;

  modport master (
    output wr_en, wr_ch, wr_data, clr_en, clr_ch, rd_en, rd_ch, rd_delay,
    input  rd_valid, rd_data, rd_oor
  );

  modport slave (
    input  wr_en, wr_ch, wr_data, clr_en, clr_ch, rd_en, rd_ch, rd_delay,
    output rd_valid, rd_data, rd_oor
  );
endinterface

// File: rtl/multichannel_history_ram.sv
// Per-channel circular sample history in one RAM addressed {ch, ptr}; reads by delay, 2-cycle latency.
// Optional HISTORY_FILL_TRACK_EN builds per-channel fill counters that flag and zero out-of-range reads.
module multichannel_history_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CH_WIDTH   = 2
) (
  input logic clk,
  input logic rst,
  multichannel_history_ram_if.slave bus
);
  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam int unsigned NCH       = 1 << CH_WIDTH;
  localparam int unsigned MEM_WORDS = 1 << (CH_WIDTH + ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [ADDR_WIDTH-1:0] wptr [NCH];

  logic                  wr_take_c;
  logic [ADDR_WIDTH-1:0] rd_ptr_c;
  logic                  rd_oor_c;

  logic                  rd_en_q;
  logic                  rd_oor_q;
  logic [DATA_WIDTH-1:0] ram_q;

  // A clear on the write channel kills the write completely; reads see pre-write pointers.
  always_comb begin
    wr_take_c = bus.wr_en && !(bus.clr_en && (bus.clr_ch == bus.wr_ch));
    rd_ptr_c  = wptr[bus.rd_ch] - ADDR_WIDTH'(1) - bus.rd_delay;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < NCH; c++) wptr[CH_WIDTH'(c)] <= '0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (bus.clr_en && (bus.clr_ch == CH_WIDTH'(c))) begin
          wptr[CH_WIDTH'(c)] <= '0;
        end else if (wr_take_c && (bus.wr_ch == CH_WIDTH'(c))) begin
          wptr[CH_WIDTH'(c)] <= wptr[CH_WIDTH'(c)] + ADDR_WIDTH'(1);
        end
      end
    end
  end

`ifdef HISTORY_FILL_TRACK_EN
  localparam logic [ADDR_WIDTH:0] FILL_MAX = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH:0] fill [NCH];

  // Saturating count of valid samples per channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < NCH; c++) fill[CH_WIDTH'(c)] <= '0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (bus.clr_en && (bus.clr_ch == CH_WIDTH'(c))) begin
          fill[CH_WIDTH'(c)] <= '0;
        end else if (wr_take_c && (bus.wr_ch == CH_WIDTH'(c)) &&
                     (fill[CH_WIDTH'(c)] != FILL_MAX)) begin
          fill[CH_WIDTH'(c)] <= fill[CH_WIDTH'(c)] + (ADDR_WIDTH + 1)'(1);
        end
      end
    end
  end

  assign rd_oor_c = ({1'b0, bus.rd_delay} >= fill[bus.rd_ch]);
`else
  assign rd_oor_c = 1'b0;
`endif

  // Block RAM: read-first, so a read of the slot being overwritten returns the evicted word.
  always_ff @(posedge clk) begin
    if (wr_take_c) mem[{bus.wr_ch, wptr[bus.wr_ch]}] <= bus.wr_data;
    if (bus.rd_en) ram_q <= mem[{bus.rd_ch, rd_ptr_c}];
  end

  // Request tracking alongside the RAM stage, then the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en_q      <= 1'b0;
      rd_oor_q     <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
      bus.rd_oor   <= 1'b0;
    end else begin
      rd_en_q      <= bus.rd_en;
      rd_oor_q     <= rd_oor_c;
      bus.rd_valid <= rd_en_q;
      if (rd_en_q) begin
        bus.rd_data <= rd_oor_q ? '0 : ram_q;
        bus.rd_oor  <= rd_oor_q;
      end
    end
  end
endmodule

// File: tb/tb_multichannel_history_ram.sv
// Directed bench for multichannel_history_ram (DEPTH=8, 4 channels); expectations follow
// whichever way HISTORY_FILL_TRACK_EN is set for the build.
module tb_multichannel_history_ram;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 3;
  localparam int unsigned CW = 2;
`ifdef HISTORY_FILL_TRACK_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  multichannel_history_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CH_WIDTH(CW)) bus ();

  multichannel_history_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CH_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [CW-1:0] ch, input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_ch   = ch;
    bus.wr_data = d;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [CW-1:0] ch, input logic [AW-1:0] d,
                          input logic [DW-1:0] exp_d, input logic exp_o);
    bus.rd_en    = 1'b1;
    bus.rd_ch    = ch;
    bus.rd_delay = d;
    step();
    bus.rd_en    = 1'b0;
    step();
    check({tag, "_v"}, 32'(bus.rd_valid), 32'd1);
    check({tag, "_d"}, bus.rd_data, exp_d);
    check({tag, "_o"}, 32'(bus.rd_oor), 32'(exp_o));
  endtask

  initial begin
    rst          = 1'b1;
    bus.wr_en    = 1'b0;
    bus.wr_ch    = '0;
    bus.wr_data  = '0;
    bus.clr_en   = 1'b0;
    bus.clr_ch   = '0;
    bus.rd_en    = 1'b0;
    bus.rd_ch    = '0;
    bus.rd_delay = '0;
    step();
    step();
    check("rst_v", 32'(bus.rd_valid), 32'd0);
    check("rst_d", bus.rd_data, 32'd0);
    check("rst_o", 32'(bus.rd_oor), 32'd0);
    rst = 1'b0;
    step();

    // Three pushes then back-to-back reads: 3,2,1 starting two cycles after the first rd_en.
    push(2'd0, 32'd1);
    push(2'd0, 32'd2);
    push(2'd0, 32'd3);
    bus.rd_en    = 1'b1;
    bus.rd_ch    = 2'd0;
    bus.rd_delay = 3'd0;
    step();
    check("t1_lat", 32'(bus.rd_valid), 32'd0);
    bus.rd_delay = 3'd1;
    step();
    check("t1_v0", 32'(bus.rd_valid), 32'd1);
    check("t1_d0", bus.rd_data, 32'd3);
    bus.rd_delay = 3'd2;
    step();
    bus.rd_en = 1'b0;
    check("t1_v1", 32'(bus.rd_valid), 32'd1);
    check("t1_d1", bus.rd_data, 32'd2);
    step();
    check("t1_v2", 32'(bus.rd_valid), 32'd1);
    check("t1_d2", bus.rd_data, 32'd1);
    step();
    check("t1_idle_v", 32'(bus.rd_valid), 32'd0);
    check("t1_hold_d", bus.rd_data, 32'd1);

    // Wrap-around: ten pushes into an 8-deep channel.
    for (int i = 0; i < 10; i++) push(2'd1, 32'(i));
    rd_check("t2_d0", 2'd1, 3'd0, 32'd9, 1'b0);
    rd_check("t2_d7", 2'd1, 3'd7, 32'd2, 1'b0);

    // Full channel: same-cycle write and oldest read returns the evicted word.
    for (int i = 0; i < 8; i++) push(2'd2, 32'h20 + 32'(i));
    bus.wr_en    = 1'b1;
    bus.wr_ch    = 2'd2;
    bus.wr_data  = 32'hAA;
    bus.rd_en    = 1'b1;
    bus.rd_ch    = 2'd2;
    bus.rd_delay = 3'd7;
    step();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    step();
    check("t3_evict_v", 32'(bus.rd_valid), 32'd1);
    check("t3_evict_d", bus.rd_data, 32'h20);
    rd_check("t3_new", 2'd2, 3'd0, 32'hAA, 1'b0);
    rd_check("t3_old", 2'd2, 3'd7, 32'h21, 1'b0);

    // Interleaved channels, then clears.
    for (int n = 0; n < 5; n++) begin
      push(2'd0, 32'h10 + 32'(n));
      push(2'd3, 32'h30 + 32'(n));
    end
    rd_check("t4_c3d4", 2'd3, 3'd4, 32'h30, 1'b0);
    rd_check("t4_c0d0", 2'd0, 3'd0, 32'h14, 1'b0);
    bus.clr_en   = 1'b1;
    bus.clr_ch   = 2'd0;
    bus.rd_en    = 1'b1;
    bus.rd_ch    = 2'd0;
    bus.rd_delay = 3'd0;
    step();
    bus.clr_en = 1'b0;
    bus.rd_en  = 1'b0;
    step();
    check("t4_preclr_d", bus.rd_data, 32'h14);
    check("t4_preclr_o", 32'(bus.rd_oor), 32'd0);
    rd_check("t4_postclr", 2'd0, 3'd0, FILL ? 32'd0 : 32'h14, FILL);
    rd_check("t4_c3_kept", 2'd3, 3'd0, 32'h34, 1'b0);
    bus.clr_en  = 1'b1;
    bus.clr_ch  = 2'd3;
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 2'd3;
    bus.wr_data = 32'h99;
    step();
    bus.clr_en = 1'b0;
    bus.wr_en  = 1'b0;
    push(2'd3, 32'h55);
    rd_check("t4_drop_d0", 2'd3, 3'd0, 32'h55, 1'b0);
    rd_check("t4_drop_d4", 2'd3, 3'd4, FILL ? 32'd0 : 32'h34, FILL);

    // Partially filled channel after reset: delay beyond fill.
    rst = 1'b1;
    step();
    rst = 1'b0;
    push(2'd1, 32'h51);
    push(2'd1, 32'h52);
    rd_check("t5_d2", 2'd1, 3'd2, FILL ? 32'd0 : 32'd7, FILL);
    rd_check("t5_d1", 2'd1, 3'd1, 32'h51, 1'b0);

    // Reset right behind a read discards it.
    bus.rd_en    = 1'b1;
    bus.rd_ch    = 2'd1;
    bus.rd_delay = 3'd0;
    step();
    bus.rd_en = 1'b0;
    rst       = 1'b1;
    step();
    check("t6_rst_v", 32'(bus.rd_valid), 32'd0);
    check("t6_rst_d", bus.rd_data, 32'd0);
    check("t6_rst_o", 32'(bus.rd_oor), 32'd0);
    rst = 1'b0;
    step();
    check("t6_after_v", 32'(bus.rd_valid), 32'd0);
    push(2'd0, 32'h77);
    rd_check("t6_d0", 2'd0, 3'd0, 32'h77, 1'b0);
    rd_check("t6_d1", 2'd0, 3'd1, FILL ? 32'd0 : 32'h14, FILL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
